lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl.sv | 100 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multicycle byte/half/word load-store unit for a word-wide synchronous RAM,
// with read-modify-write lane stores and fault reporting for illegal or misaligned accesses.
module lsu_mem_ctrl #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [2:0]    i_ctrl,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_ready,
    output logic          o_done,
    output logic          o_fault,
    output logic [31:0]   o_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic          r_we;
    logic [2:0]    r_ctrl;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_merge;
    logic [31:0]   r_rdata;
    logic          w_fault;
    logic [4:0]    w_sh;
    logic [31:0]   w_mask;
    logic [31:0]   w_lane;
    logic [31:0]   w_ext;
    logic          w_unused;

    assign w_unused = ^i_addr[31:AW+2];
    assign w_fault  = (i_ctrl == 3'b011) || (i_ctrl[2:1] == 2'b11) || (i_we && i_ctrl[2])
                   || (i_ctrl[1:0] == 2'b01 && i_addr[0]) || (i_ctrl[1:0] == 2'b10 && i_addr[1:0] != 2'b00);

    // lane shift: halfwords use addr[1], bytes use addr[1:0]
    assign w_sh   = r_ctrl[0] ? {r_addr[1], 4'b0} : {r_addr[1:0], 3'b0};
    assign w_mask = r_ctrl[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    assign w_lane = i_mem_rdata >> w_sh;
    assign w_ext  = r_ctrl[1] ? i_mem_rdata
                  : r_ctrl[0] ? {{16{~r_ctrl[2] & w_lane[15]}}, w_lane[15:0]}
                  : {{24{~r_ctrl[2] & w_lane[7]}}, w_lane[7:0]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !i_req ? S_IDLE : w_fault ? S_ERR : (i_we && i_ctrl[1]) ? S_WRITE : S_READ;
            S_READ:  w_next = S_WAIT;
            S_WAIT:  w_next = r_we ? S_WRITE : S_DONE;
            S_WRITE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_ctrl  <= 3'b0;
            r_addr  <= '0;
            r_wdata <= 32'b0;
            r_merge <= 32'b0;
            r_rdata <= 32'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req) begin
                r_we    <= i_we;
                r_ctrl  <= i_ctrl;
                r_addr  <= i_addr[AW+1:0];
                r_wdata <= i_wdata;
            end
            if (r_state == S_WAIT && r_we)
                r_merge <= (i_mem_rdata & ~(w_mask << w_sh)) | ((r_wdata & w_mask) << w_sh);
            if (r_state == S_WAIT && !r_we)
                r_rdata <= w_ext;
        end
    end

    assign o_ready     = r_state == S_IDLE;
    assign o_done      = r_state == S_DONE || r_state == S_ERR;
    assign o_fault     = r_state == S_ERR;
    assign o_rdata     = r_rdata;
    assign o_mem_en    = i_rst_n && (r_state == S_READ || r_state == S_WRITE);
    assign o_mem_we    = i_rst_n && r_state == S_WRITE;
    assign o_mem_addr  = r_addr[AW+1:2];
    assign o_mem_wdata = r_ctrl[1] ? r_wdata : r_merge;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl against a byte-level memory model.
module tb_lsu_mem_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    ctrl = 3'b0;
    logic [31:0]   addr = 32'b0;
    logic [31:0]   wdata = 32'b0;
    logic          ready, done, fault, mem_en, mem_we;
    logic [31:0]   rdata, mem_wdata;
    logic [31:0]   mem_rdata = 32'b0;
    logic [AW-1:0] mem_addr;

    logic [31:0]   ram [0:1023];
    logic [31:0]   ref_mem [0:1023];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [31:0]   pre_d = 32'b0;

    typedef struct {
        bit            flt;
        logic [31:0]   rd;
        int            cyc;
        int            lat;
        int            nrd;
        int            nwr;
        logic [AW-1:0] wa;
        logic [31:0]   wword;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdcnt = 0;
    int          wrcnt = 0;
    bit          skip = 1'b0;
    logic [31:0] m_rdata = 32'b0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_ctrl(ctrl),
        .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_done(done),
        .o_fault(fault), .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) ram[pre_a] <= pre_d;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed view of the word memory
    task automatic predict(input bit w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          size, off;
        logic [31:0] word;
        bit          legal;
        size  = (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        legal = (c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(w && c >= 3'd4) && (off % size == 0);
        e.cyc = cyc; e.wa = a[AW+1:2]; e.flt = !legal; e.nrd = 0; e.nwr = 0; e.wword = 32'b0; e.lat = 1;
        if (legal && !w) begin
            word = ref_mem[e.wa] >> (8 * off);
            if (size == 1) m_rdata = c[2] ? {24'b0, word[7:0]} : {{24{word[7]}}, word[7:0]};
            else if (size == 2) m_rdata = c[2] ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]};
            else m_rdata = word;
            e.lat = 3; e.nrd = 1;
        end else if (legal) begin
            word = ref_mem[e.wa];
            for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
            ref_mem[e.wa] = word;
            e.wword = word; e.nwr = 1;
            e.lat = (size == 4) ? 2 : 4;
            e.nrd = (size == 4) ? 0 : 1;
        end
        e.rd = m_rdata;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rdcnt = 0; wrcnt = 0; m_rdata = 32'b0;
            chk("strobe_in_reset", {30'b0, mem_en, mem_we}, 32'b0);
        end else begin
            if (q.size() > 0) chk("ready_busy", {31'b0, ready}, 32'b0);
            if (ready && req && !skip) predict(we, ctrl, addr, wdata);
            if (mem_en && !skip) begin
                if (q.size() == 0) chk("stray_strobe", {31'b0, mem_en}, 32'b0);
                else begin
                    chk("mem_addr", {22'b0, mem_addr}, {22'b0, q[0].wa});
                    if (mem_we) begin
                        wrcnt++;
                        chk("mem_wdata", mem_wdata, q[0].wword);
                    end else rdcnt++;
                end
            end
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", {31'b0, done}, 32'b0);
                else begin
                    e = q.pop_front();
                    chk("fault", {31'b0, fault}, {31'b0, e.flt});
                    chk("rdata", rdata, e.rd);
                    chk("latency", cyc - e.cyc, e.lat);
                    chk("ram_reads", rdcnt, e.nrd);
                    chk("ram_writes", wrcnt, e.nwr);
                end
                rdcnt = 0; wrcnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready && q.size() == 0) break;
        end
        if (k == 20) begin
            checks++; errors++;
            $display("FAIL timeout: got no completion within 20 cycles, expected done");
        end
        @(posedge clk); #1;
    endtask

    task automatic acc(input bit w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; ctrl = c; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle();
    endtask

    task automatic rand_fields();
        we    = 1'($urandom);
        ctrl  = 3'($urandom_range(0, 7));
        addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
        wdata = $urandom;
    endtask

    initial begin
        logic [31:0] saved;
        pre_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pre_a = AW'(i); pre_d = $urandom; ref_mem[i] = pre_d;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_fault", {31'b0, fault}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        acc(1, 3'b010, 32'h10, 32'hDEADBEEF);
        acc(0, 3'b010, 32'h10, 32'h0);
        chk("LW_10", rdata, 32'hDEADBEEF);
        acc(1, 3'b010, 32'h10, 32'h11223344);
        acc(1, 3'b000, 32'h12, 32'h000000AA);
        chk("SB_merge", ram[4], 32'h11AA3344);
        acc(1, 3'b010, 32'h10, 32'h80FF7F01);
        acc(0, 3'b000, 32'h13, 32'h0); chk("LB_13", rdata, 32'hFFFFFF80);
        acc(0, 3'b100, 32'h13, 32'h0); chk("LBU_13", rdata, 32'h00000080);
        acc(0, 3'b001, 32'h12, 32'h0); chk("LH_12", rdata, 32'hFFFF80FF);
        acc(0, 3'b101, 32'h10, 32'h0); chk("LHU_10", rdata, 32'h00007F01);
        acc(0, 3'b010, 32'h11, 32'h0);
        acc(1, 3'b001, 32'h13, 32'h5555);
        acc(0, 3'b011, 32'h10, 32'h0);
        acc(1, 3'b100, 32'h10, 32'h77);
        chk("fault_rdata_held", rdata, 32'h00007F01);
        chk("fault_ram_intact", ram[4], 32'h80FF7F01);

        repeat (150) begin
            rand_fields();
            acc(we, ctrl, addr, wdata);
        end

        req = 1'b1;
        repeat (300) begin
            rand_fields();
            @(posedge clk); #1;
        end
        req = 1'b0;
        wait_idle();

        acc(1, 3'b010, 32'h14, 32'h12345678);
        acc(0, 3'b010, 32'h14, 32'h0);
        saved = ram[5];
        skip = 1'b1;
        req = 1'b1; we = 1'b1; ctrl = 3'b001; addr = 32'h16; wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmw_abort_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        skip = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_done", {31'b0, done}, 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_ram", ram[5], saved);
        chk("post_rst_ram_val", ram[5], 32'h12345678);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) chk("ram_final", ram[i], ref_mem[i]);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
